// File: rtl/lzw_forward_prepare_mc.sv
// Store-and-forward frame splitter: header/payload FIFOs with commit/rollback; commit 1 cycle after en falls, rdata 1-cycle latency.
// No ingress backpressure: overflowing frames are rolled back and counted; egress is req/ack plus free-running rd strobes.

module lzw_fpm_fifo #(
    parameter int W  = 1,
    parameter int AW = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    logic [W-1:0] r_mem [2**AW];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_dout  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full) r_wptr <= r_wptr + 1'b1;
            if (i_pop && !o_empty) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_din;
    end
endmodule

module lzw_forward_prepare_mc #(
    parameter int DW       = 8,
    parameter int HEAD_LEN = 14,
    parameter int HEAD_AW  = 6,
    parameter int PLOAD_AW = 11,
    parameter int FRM_AW   = 4
) (
    input  logic          I_sys_clk,
    input  logic          I_sys_rst,
    input  logic [DW-1:0] I_tx_gmii_data,
    input  logic          I_tx_gmii_data_en,
    output logic          O_head_no_pload,
    output logic          O_fifo_head_req,
    input  logic          I_fifo_head_ack,
    input  logic          I_fifo_head_rd,
    output logic [DW:0]   O_fifo_head_rdata,
    output logic          O_fifo_head_full,
    output logic          O_fifo_head_empty,
    output logic          O_fifo_pload_req,
    input  logic          I_fifo_pload_ack,
    input  logic          I_fifo_pload_rd,
    output logic [DW:0]   O_fifo_pload_rdata,
    output logic          O_fifo_pload_empty,
    output logic          O_fifo_pload_full,
    output logic [DW-1:0] O_pload_txd,
    output logic          O_pload_txen,
    output logic [15:0]   O_drop_cnt
);
    localparam int CW = $clog2(HEAD_LEN + 1);
    localparam logic [CW-1:0] L_HL  = CW'(HEAD_LEN);
    localparam logic [CW-1:0] L_HL1 = CW'(HEAD_LEN - 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAD = 2'd1;
    localparam logic [1:0] S_PLOAD = 2'd2;
    localparam logic [1:0] S_DISC = 2'd3;

    logic [1:0]     r_state;
    logic           r_en_d;
    logic [CW-1:0]  r_cnt;
    logic           r_pend_vld, r_pend_head, r_pend_hlast;
    logic [DW-1:0]  r_pend_dat;
    logic [DW:0]    r_h_mem [2**HEAD_AW];
    logic [DW:0]    r_p_mem [2**PLOAD_AW];
    logic [HEAD_AW:0]  r_h_wptr, r_h_cptr, r_h_rptr;
    logic [PLOAD_AW:0] r_p_wptr, r_p_cptr, r_p_rptr;
    logic [FRM_AW:0] r_h_frm, r_p_frm;
    logic           r_h_serv, r_p_serv;
    logic [DW:0]    r_h_rdata, r_p_rdata;
    logic [DW-1:0]  r_txd;
    logic           r_txen;
    logic [15:0]    r_drop_cnt;

    wire w_en     = I_tx_gmii_data_en;
    wire w_active = (r_state == S_HEAD) || (r_state == S_PLOAD);
    wire w_wr     = r_pend_vld && w_active;
    // The pending word is the final one exactly when en has just fallen.
    wire w_last   = r_pend_head ? (r_pend_hlast || !w_en) : !w_en;
    wire [DW:0] w_wdat = {w_last, r_pend_dat};
    wire w_h_wr   = w_wr && r_pend_head;
    wire w_p_wr   = w_wr && !r_pend_head;
    wire w_h_full = (r_h_wptr[HEAD_AW] != r_h_rptr[HEAD_AW]) &&
                    (r_h_wptr[HEAD_AW-1:0] == r_h_rptr[HEAD_AW-1:0]);
    wire w_p_full = (r_p_wptr[PLOAD_AW] != r_p_rptr[PLOAD_AW]) &&
                    (r_p_wptr[PLOAD_AW-1:0] == r_p_rptr[PLOAD_AW-1:0]);
    wire w_h_empty = (r_h_cptr == r_h_rptr);
    wire w_p_empty = (r_p_cptr == r_p_rptr);
    wire w_ovf    = (w_h_wr && w_h_full) || (w_p_wr && w_p_full);
    wire w_d_full, w_d_empty, w_d_dout;
    wire w_sof    = (r_state == S_IDLE) && w_en && !r_en_d;
    wire w_drop   = w_ovf || (w_sof && w_d_full);
    wire w_commit = w_active && !w_en && !w_ovf;
    wire w_p_inc  = w_commit && !r_pend_head;
    wire w_h_rd   = I_fifo_head_rd && !w_h_empty;
    wire w_p_rd   = I_fifo_pload_rd && !w_p_empty;
    wire [DW:0] w_h_rword = r_h_mem[r_h_rptr[HEAD_AW-1:0]];
    wire [DW:0] w_p_rword = r_p_mem[r_p_rptr[PLOAD_AW-1:0]];
    wire w_h_dec  = w_h_rd && w_h_rword[DW];
    wire w_p_dec  = w_p_rd && w_p_rword[DW];
    wire w_h_req  = (r_h_frm != '0) && !r_h_serv;
    wire w_p_req  = (r_p_frm != '0) && !r_p_serv;
    wire w_echo   = w_active && w_en && (r_cnt == L_HL) && !w_ovf;

    lzw_fpm_fifo #(.W(1), .AW(FRM_AW)) u_desc (
        .i_clk(I_sys_clk), .i_rst(I_sys_rst),
        .i_push(w_commit), .i_din(r_pend_head), .i_pop(w_h_dec),
        .o_dout(w_d_dout), .o_full(w_d_full), .o_empty(w_d_empty)
    );

    always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
        if (I_sys_rst) begin
            r_state <= S_IDLE;
            r_en_d <= 1'b1;   // a frame already in flight at reset release is ignored
            r_cnt <= '0;
            r_pend_vld <= 1'b0;
            r_pend_head <= 1'b0;
            r_pend_hlast <= 1'b0;
            r_pend_dat <= '0;
        end else begin
            r_en_d <= w_en;
            case (r_state)
                S_IDLE: if (w_sof) begin
                    if (w_d_full) r_state <= S_DISC;
                    else begin
                        r_state <= S_HEAD;
                        r_pend_vld <= 1'b1;
                        r_pend_dat <= I_tx_gmii_data;
                        r_pend_head <= 1'b1;
                        r_pend_hlast <= (HEAD_LEN == 1);
                        r_cnt <= CW'(1);
                    end
                end
                S_HEAD, S_PLOAD: begin
                    if (w_ovf) begin
                        r_state <= w_en ? S_DISC : S_IDLE;
                        r_pend_vld <= 1'b0;
                    end else if (w_en) begin
                        r_pend_dat <= I_tx_gmii_data;
                        r_pend_head <= (r_cnt != L_HL);
                        r_pend_hlast <= (r_cnt == L_HL1);
                        if (r_cnt != L_HL) r_cnt <= r_cnt + 1'b1;
                        r_state <= (r_cnt != L_HL) ? S_HEAD : S_PLOAD;
                    end else begin
                        r_state <= S_IDLE;
                        r_pend_vld <= 1'b0;
                    end
                end
                default: if (!w_en) r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (w_h_wr && !w_h_full) r_h_mem[r_h_wptr[HEAD_AW-1:0]] <= w_wdat;
        if (w_p_wr && !w_p_full) r_p_mem[r_p_wptr[PLOAD_AW-1:0]] <= w_wdat;
    end

    always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
        if (I_sys_rst) begin
            r_h_wptr <= '0; r_h_cptr <= '0; r_h_rptr <= '0;
            r_p_wptr <= '0; r_p_cptr <= '0; r_p_rptr <= '0;
            r_h_frm <= '0; r_p_frm <= '0;
            r_h_serv <= 1'b0; r_p_serv <= 1'b0;
            r_h_rdata <= '0; r_p_rdata <= '0;
            r_txd <= '0; r_txen <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_h_wptr <= r_h_cptr;
                r_p_wptr <= r_p_cptr;
            end else begin
                if (w_h_wr) r_h_wptr <= r_h_wptr + 1'b1;
                if (w_p_wr) r_p_wptr <= r_p_wptr + 1'b1;
            end
            if (w_commit) begin
                r_h_cptr <= r_h_wptr + {{HEAD_AW{1'b0}}, w_h_wr};
                r_p_cptr <= r_p_wptr + {{PLOAD_AW{1'b0}}, w_p_wr};
            end
            if (w_h_rd) begin
                r_h_rptr <= r_h_rptr + 1'b1;
                r_h_rdata <= w_h_rword;
            end
            if (w_p_rd) begin
                r_p_rptr <= r_p_rptr + 1'b1;
                r_p_rdata <= w_p_rword;
            end
            r_h_frm <= r_h_frm + {{FRM_AW{1'b0}}, w_commit} - {{FRM_AW{1'b0}}, w_h_dec};
            r_p_frm <= r_p_frm + {{FRM_AW{1'b0}}, w_p_inc} - {{FRM_AW{1'b0}}, w_p_dec};
            if (w_h_dec) r_h_serv <= 1'b0;
            else if (I_fifo_head_ack && w_h_req) r_h_serv <= 1'b1;
            if (w_p_dec) r_p_serv <= 1'b0;
            else if (I_fifo_pload_ack && w_p_req) r_p_serv <= 1'b1;
            r_txen <= w_echo;
            if (w_echo) r_txd <= I_tx_gmii_data;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign O_head_no_pload    = !w_d_empty && w_d_dout;
    assign O_fifo_head_req    = w_h_req;
    assign O_fifo_head_rdata  = r_h_rdata;
    assign O_fifo_head_full   = w_h_full;
    assign O_fifo_head_empty  = w_h_empty;
    assign O_fifo_pload_req   = w_p_req;
    assign O_fifo_pload_rdata = r_p_rdata;
    assign O_fifo_pload_full  = w_p_full;
    assign O_fifo_pload_empty = w_p_empty;
    assign O_pload_txd        = r_txd;
    assign O_pload_txen       = r_txen;
    assign O_drop_cnt         = r_drop_cnt;
endmodule

// File: tb/tb_lzw_forward_prepare_mc.sv
// Scoreboard bench for lzw_forward_prepare_mc: directed frames push expected FIFO words and echoes,
// a negedge monitor pops and compares whenever read data or echo data is presented.
module tb_lzw_forward_prepare_mc;
    localparam int HL = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       en;
    logic       no_pload, h_req, h_ack, h_rd, h_full, h_empty;
    logic       p_req, p_ack, p_rd, p_full, p_empty;
    logic [8:0] h_rdata, p_rdata;
    logic [7:0] txd;
    logic       txen;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    lzw_forward_prepare_mc #(.DW(8), .HEAD_LEN(HL), .HEAD_AW(6), .PLOAD_AW(4), .FRM_AW(4)) dut (
        .I_sys_clk(clk), .I_sys_rst(rst),
        .I_tx_gmii_data(data), .I_tx_gmii_data_en(en),
        .O_head_no_pload(no_pload),
        .O_fifo_head_req(h_req), .I_fifo_head_ack(h_ack), .I_fifo_head_rd(h_rd),
        .O_fifo_head_rdata(h_rdata), .O_fifo_head_full(h_full), .O_fifo_head_empty(h_empty),
        .O_fifo_pload_req(p_req), .I_fifo_pload_ack(p_ack), .I_fifo_pload_rd(p_rd),
        .O_fifo_pload_rdata(p_rdata), .O_fifo_pload_empty(p_empty), .O_fifo_pload_full(p_full),
        .O_pload_txd(txd), .O_pload_txen(txen), .O_drop_cnt(drop_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [8:0] q_head[$];
    logic [8:0] q_pload[$];
    logic [7:0] q_echo[$];
    bit echo_chk = 1'b0;
    bit h_pend = 1'b0, p_pend = 1'b0;
    bit watch_preq = 1'b0, seen_preq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: DUT output with nothing expected", name);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            h_pend = 1'b0;
            p_pend = 1'b0;
        end else begin
            if (h_pend) begin
                if (q_head.size() == 0) miss("head_rdata");
                else chk("head_rdata", h_rdata, q_head.pop_front());
            end
            if (p_pend) begin
                if (q_pload.size() == 0) miss("pload_rdata");
                else chk("pload_rdata", p_rdata, q_pload.pop_front());
            end
            h_pend = h_rd && !h_empty;
            p_pend = p_rd && !p_empty;
            if (txen && echo_chk) begin
                if (q_echo.size() == 0) miss("echo");
                else chk("echo_txd", txd, q_echo.pop_front());
            end
            if (watch_preq && p_req) seen_preq = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives len contiguous words base+i; en is left low on return (caller adds the gap).
    task automatic send(input int len, input logic [7:0] base, input bit ok);
        logic [7:0] d;
        logic [8:0] e;
        for (int i = 0; i < len; i++) begin
            d = base + 8'(i);
            data = d;
            en = 1'b1;
            if (ok) begin
                if (i < HL) begin
                    e = {(i == HL - 1) || (i == len - 1), d};
                    q_head.push_back(e);
                end else begin
                    e = {(i == len - 1), d};
                    q_pload.push_back(e);
                    q_echo.push_back(d);
                end
            end
            @(posedge clk);
            #1;
        end
        en = 1'b0;
        data = 8'h00;
    endtask

    task automatic rd_head(input int n);
        h_rd = 1'b1;
        cyc(n);
        h_rd = 1'b0;
    endtask

    task automatic rd_pload(input int n);
        p_rd = 1'b1;
        cyc(n);
        p_rd = 1'b0;
    endtask

    task automatic ack_head();
        h_ack = 1'b1;
        cyc(1);
        h_ack = 1'b0;
    endtask

    task automatic ack_pload();
        p_ack = 1'b1;
        cyc(1);
        p_ack = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_h_req"}, h_req, 0);
        chk({tag, "_p_req"}, p_req, 0);
        chk({tag, "_h_rdata"}, h_rdata, 0);
        chk({tag, "_p_rdata"}, p_rdata, 0);
        chk({tag, "_h_empty"}, h_empty, 1);
        chk({tag, "_p_empty"}, p_empty, 1);
        chk({tag, "_h_full"}, h_full, 0);
        chk({tag, "_p_full"}, p_full, 0);
        chk({tag, "_no_pload"}, no_pload, 0);
        chk({tag, "_txd"}, txd, 0);
        chk({tag, "_txen"}, txen, 0);
        chk({tag, "_drop"}, drop_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; data = 8'h00; en = 1'b0;
        h_ack = 1'b0; h_rd = 1'b0; p_ack = 1'b0; p_rd = 1'b0;
        cyc(3);
        chk_reset_outputs("por");
        rst = 1'b0;
        cyc(2);

        // 20-word frame: 14 header words, 6 payload words
        echo_chk = 1'b1;
        send(20, 8'h00, 1'b1);
        chk("t1_h_req_at_commit", h_req, 0);
        chk("t1_h_empty_at_commit", h_empty, 1);
        cyc(1);
        chk("t1_h_req", h_req, 1);
        chk("t1_p_req", p_req, 1);
        chk("t1_no_pload", no_pload, 0);
        chk("t1_h_empty", h_empty, 0);
        chk("t1_p_empty", p_empty, 0);
        ack_head();
        chk("t1_h_req_after_ack", h_req, 0);
        rd_head(14);
        ack_pload();
        chk("t1_p_req_after_ack", p_req, 0);
        rd_pload(6);
        cyc(2);
        chk("t1_h_empty_end", h_empty, 1);
        chk("t1_p_empty_end", p_empty, 1);
        chk("t1_h_req_end", h_req, 0);
        chk("t1_p_req_end", p_req, 0);
        chk("t1_echo_drained", q_echo.size(), 0);

        // 10-word then 14-word frame: header only, req re-rises for the queued frame
        watch_preq = 1'b1;
        seen_preq = 1'b0;
        send(10, 8'h20, 1'b1);
        cyc(1);
        send(14, 8'h30, 1'b1);
        cyc(1);
        chk("t2_no_pload_a", no_pload, 1);
        chk("t2_h_req", h_req, 1);
        ack_head();
        chk("t2_h_req_after_ack", h_req, 0);
        rd_head(10);
        chk("t2_h_req_rerise", h_req, 1);
        chk("t2_no_pload_b", no_pload, 1);
        ack_head();
        rd_head(14);
        cyc(2);
        chk("t2_no_pload_end", no_pload, 0);
        chk("t2_h_empty_end", h_empty, 1);
        chk("t2_h_req_end", h_req, 0);
        chk("t2_p_empty", p_empty, 1);
        chk("t2_p_req_never", seen_preq, 0);
        watch_preq = 1'b0;

        // 40-word frame overflows the 16-entry payload FIFO
        echo_chk = 1'b0;
        send(40, 8'h40, 1'b0);
        cyc(3);
        q_echo.delete();
        echo_chk = 1'b1;
        chk("t3_drop", drop_cnt, 1);
        chk("t3_h_empty", h_empty, 1);
        chk("t3_p_empty", p_empty, 1);
        chk("t3_h_req", h_req, 0);
        chk("t3_p_full", p_full, 0);
        send(20, 8'h80, 1'b1);
        cyc(1);
        chk("t3_next_h_req", h_req, 1);
        chk("t3_next_p_req", p_req, 1);
        ack_head();
        ack_pload();
        rd_head(14);
        rd_pload(6);
        cyc(2);
        chk("t3_next_h_empty", h_empty, 1);
        chk("t3_next_p_empty", p_empty, 1);

        // reset in the middle of the payload; the tail must be ignored
        echo_chk = 1'b0;
        for (int i = 0; i < 17; i++) begin
            data = 8'hA0 + 8'(i);
            en = 1'b1;
            cyc(1);
        end
        rst = 1'b1;
        data = 8'hB1;
        cyc(2);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data = 8'hB2 + 8'(i);
            cyc(1);
        end
        en = 1'b0;
        data = 8'h00;
        cyc(3);
        q_echo.delete();
        echo_chk = 1'b1;
        chk("t4_tail_h_empty", h_empty, 1);
        chk("t4_tail_h_req", h_req, 0);
        chk("t4_tail_drop", drop_cnt, 0);
        send(16, 8'hC0, 1'b1);
        cyc(1);
        chk("t4_next_h_req", h_req, 1);
        chk("t4_next_p_req", p_req, 1);
        rd_head(14);
        rd_pload(2);
        cyc(2);
        chk("t4_next_h_empty", h_empty, 1);
        chk("t4_next_p_empty", p_empty, 1);

        // 16 short frames fill the descriptor FIFO; the 17th is dropped
        for (int i = 0; i < 16; i++) begin
            send(2, 8'hE0 + 8'(2 * i), 1'b1);
            cyc(1);
        end
        chk("t5_no_pload", no_pload, 1);
        chk("t5_h_full", h_full, 0);
        chk("t5_drop_before", drop_cnt, 0);
        send(2, 8'h10, 1'b0);
        cyc(1);
        chk("t5_drop", drop_cnt, 1);
        chk("t5_h_empty", h_empty, 0);
        rd_head(32);
        cyc(2);
        chk("t5_h_empty_end", h_empty, 1);
        chk("t5_h_req_end", h_req, 0);
        chk("t5_no_pload_end", no_pload, 0);
        h_rd = 1'b1;
        cyc(2);
        h_rd = 1'b0;
        cyc(1);
        chk("t5_rdata_hold", h_rdata, 9'h1FF);

        cyc(3);
        chk("q_head_drained", q_head.size(), 0);
        chk("q_pload_drained", q_pload.size(), 0);
        chk("q_echo_drained", q_echo.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
